fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
Parametrised single-clock synchronous FIFO, the successor to the fixed 8x16 FIFO. It adds configurable width, depth and thresholds; a selectable read mode (registered or first-word-fall-through); and simultaneous read/write. It also provides an occupancy count, almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It is used as the general buffering element between datapath stages in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=4
AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read (data one cycle after accepted re); 1 = first-word-fall-through
ADDR_W, $clog2(DEPTH), derived pointer width; not to be overridden

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush, active-high
we  input  1  write request
re  input  1  read request
data_in  input  WIDTH  write data
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst low, async):
  - rd_ptr, wr_ptr and count go to 0; overflow and underflow go to 0.
  - data_out goes to 0 in FWFT=0.
  - Storage array is not reset.
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=0.
- Acceptance: wr_ok = we & !full; rd_ok = re & !empty. Both are evaluated on pre-edge state.
- On wr_ok: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping modulo DEPTH.
- On rd_ok: rd_ptr increments, wrapping modulo DEPTH.
- Count update: +1 if wr_ok only; -1 if rd_ok only; unchanged if both or neither.
- Simultaneous re & we when 0 < count < DEPTH: both accepted; count unchanged.
- Full with re & we: read accepted, write rejected; count becomes DEPTH-1; overflow sets.
- Empty with re & we: write accepted, read rejected; count becomes 1; underflow sets. No bypass of the written word to the output.
- Error flags:
  - overflow sets on (we & full); underflow sets on (re & empty).
  - Both hold until rst or clear.
  - A rejected access does not alter any pointer, the count or data_out.
- Read mode FWFT=0:
  - data_out <= mem[rd_ptr] on rd_ok, i.e. valid the cycle after re is sampled.
  - Otherwise data_out holds its value.
- Read mode FWFT=1:
  - data_out = mem[rd_ptr] combinationally; the head word is visible whenever empty=0.
  - re acknowledges and pops the head.
  - data_out is don't-care while empty=1.
- Flags and count are registered or derived from registered count; no combinational path from we/re to any flag.
- Clear:
  - Synchronous; takes priority over we/re in the same cycle.
  - Zeroes pointers, count, overflow and underflow, and data_out (FWFT=0).
  - Storage contents are untouched but unreachable.
- Reset mid-operation: takes effect immediately, regardless of clk; all in-flight accesses are discarded.
- Latency: write-to-empty-deassert is 1 cycle. With FWFT=1, the written word is visible on data_out in that same cycle.

Test Plan:
1. Reset/defaults (WIDTH=8, DEPTH=16, FWFT=0): hold rst low, release -> count=0, empty=1, almost_empty=1, full=0, data_out=0x00, overflow=underflow=0.
2. Fill and drain: write 0x00..0x0F on 16 consecutive cycles. Expect almost_full=1 from count=12 and full=1 at count=16. Then read 16 times -> data_out sequence 0x00..0x0F, each one cycle after re; empty=1 at end; almost_empty=1 once count<=4.
3. Boundary errors: with full, pulse we with 0xAA -> count stays 16, overflow=1, later reads never return 0xAA. With empty, pulse re -> underflow=1, data_out unchanged, count=0.
4. Simultaneous access: at count=5, assert re & we for 10 cycles -> count stays 5 and data order is preserved. At full with re & we -> count=15, overflow=1. At empty with re & we -> count=1, underflow=1.
5. Wrap-around and clear: do 40 writes and 40 reads interleaved so pointers wrap twice -> no data loss, in order. Then, at count=7, assert clear together with we -> count=0, empty=1, flags cleared, the write is ignored.
6. FWFT=1: write 0x3C into empty FIFO -> data_out=0x3C after that edge with no re. Pulse re -> empty=1. Assert rst low asynchronously between edges -> count=0 immediately.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// error flags, synchronous flush and selectable registered / fall-through read.
module fifo_sync_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              we,
  input  logic              re,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_ok, rd_ok;

  // Flags decode only the registered count, so we/re never reach them combinationally.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    count        = count_q;
    overflow     = ovf_q;
    underflow    = udf_q;
    wr_ok        = we & ~full;
    rd_ok        = re & ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (we & full)  ovf_d = 1'b1;
      if (re & empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT == 0) begin : g_reg_read
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (clear)      dout_d = '0;
      else if (rd_ok) dout_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) dout_q <= '0;
      else      dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end else begin : g_fwft_read
    assign data_out = mem_q[rd_ptr_q];
  end

endmodule
